// File: rtl/ahbl_arbiter_if.sv
// rtl/ahbl_arbiter_if.sv - AHB-lite N:1 arbiter bundle: upstream master ports and the single downstream bus
interface ahbl_arbiter_if #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
);
   logic [N_PORTS-1:0]        src_hready;
   logic [N_PORTS-1:0]        src_hready_resp;
   logic [N_PORTS-1:0]        src_hresp;
   logic [N_PORTS*W_ADDR-1:0] src_haddr;
   logic [N_PORTS-1:0]        src_hwrite;
   logic [N_PORTS*2-1:0]      src_htrans;
   logic [N_PORTS*3-1:0]      src_hsize;
   logic [N_PORTS*3-1:0]      src_hburst;
   logic [N_PORTS*4-1:0]      src_hprot;
   logic [N_PORTS-1:0]        src_hmastlock;
   logic [N_PORTS-1:0]        src_hexcl;
   logic [N_PORTS*8-1:0]      src_hmaster;
   logic [N_PORTS*W_ADDR-1:0] src_d_pc;
   logic [N_PORTS*W_DATA-1:0] src_hartid;
   logic [N_PORTS*W_DATA-1:0] src_hwdata;
   logic [N_PORTS*W_DATA-1:0] src_hrdata;
   logic [N_PORTS-1:0]        src_hexokay;

   logic                      dst_hready;
   logic                      dst_hready_resp;
   logic                      dst_hresp;
   logic [W_ADDR-1:0]         dst_haddr;
   logic                      dst_hwrite;
   logic [1:0]                dst_htrans;
   logic [2:0]                dst_hsize;
   logic [2:0]                dst_hburst;
   logic [3:0]                dst_hprot;
   logic                      dst_hmastlock;
   logic                      dst_hexcl;
   logic [7:0]                dst_hmaster;
   logic [W_ADDR-1:0]         dst_d_pc;
   logic [W_DATA-1:0]         dst_hartid;
   logic [W_DATA-1:0]         dst_hwdata;
   logic [W_DATA-1:0]         dst_hrdata;
   logic                      dst_hexokay;

   // Arbiter view: slave towards the upstream masters, master towards the downstream bus.
   modport slave (
      input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot,
             src_hmastlock, src_hexcl, src_hmaster, src_d_pc, src_hartid, src_hwdata,
      output src_hready_resp, src_hresp, src_hrdata, src_hexokay,
      output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot,
             dst_hmastlock, dst_hexcl, dst_hmaster, dst_d_pc, dst_hartid, dst_hwdata,
      input  dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay
   );

   modport master (
      output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot,
             src_hmastlock, src_hexcl, src_hmaster, src_d_pc, src_hartid, src_hwdata,
      input  src_hready_resp, src_hresp, src_hrdata, src_hexokay,
      input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot,
             dst_hmastlock, dst_hexcl, dst_hmaster, dst_d_pc, dst_hartid, dst_hwdata,
      output dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay
   );
endinterface

// File: rtl/ahbl_arbiter.sv
// rtl/ahbl_arbiter.sv - AHB-lite N:1 fixed-priority arbiter with per-port address-phase replay buffers
module ahbl_arbiter #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
) (
   input  logic          clk,
   input  logic          rst,
   ahbl_arbiter_if.slave bus
);
   typedef struct packed {
      logic [W_ADDR-1:0] haddr;
      logic              hwrite;
      logic [1:0]        htrans;
      logic [2:0]        hsize;
      logic [2:0]        hburst;
      logic [3:0]        hprot;
      logic              hmastlock;
      logic              hexcl;
      logic [7:0]        hmaster;
      logic [W_ADDR-1:0] d_pc;
      logic [W_DATA-1:0] hartid;
   } aph_t;

   aph_t               live_aph [N_PORTS];
   aph_t               pend_aph [N_PORTS];
   aph_t               buf_q    [N_PORTS];
   aph_t               sel_aph;
   logic [N_PORTS-1:0] live;
   logic [N_PORTS-1:0] pend;
   logic [N_PORTS-1:0] grant;
   logic               found;
   logic               accept;

   logic [N_PORTS-1:0] buf_valid_q;
   logic [N_PORTS-1:0] mast_sel_q;
   logic [N_PORTS-1:0] hold_port_q;
   logic               lock_q;
   logic               hold_valid_q;

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         live_aph[i].haddr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
         live_aph[i].hwrite    = bus.src_hwrite[i];
         live_aph[i].htrans    = bus.src_htrans[i*2 +: 2];
         live_aph[i].hsize     = bus.src_hsize[i*3 +: 3];
         live_aph[i].hburst    = bus.src_hburst[i*3 +: 3];
         live_aph[i].hprot     = bus.src_hprot[i*4 +: 4];
         live_aph[i].hmastlock = bus.src_hmastlock[i];
         live_aph[i].hexcl     = bus.src_hexcl[i];
         live_aph[i].hmaster   = bus.src_hmaster[i*8 +: 8];
         live_aph[i].d_pc      = bus.src_d_pc[i*W_ADDR +: W_ADDR];
         live_aph[i].hartid    = bus.src_hartid[i*W_DATA +: W_DATA];
      end
   end

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         live[i]     = bus.src_hready[i] && bus.src_htrans[i*2+1];
         pend[i]     = buf_valid_q[i] || live[i];
         pend_aph[i] = buf_valid_q[i] ? buf_q[i] : live_aph[i];
      end
   end

   // A stalled address phase is frozen on its port; a lock pins the bus to the locked master.
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (hold_valid_q) begin
         grant = hold_port_q;
      end else if (lock_q) begin
         grant = mast_sel_q & pend;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (pend[i] && !found) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_aph = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant[i]) sel_aph = pend_aph[i];
      end
   end

   always_comb begin
      bus.dst_hwdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (mast_sel_q[i]) bus.dst_hwdata = bus.src_hwdata[i*W_DATA +: W_DATA];
      end
   end

   assign accept            = (|grant) && bus.dst_hready_resp;

   assign bus.dst_hready    = bus.dst_hready_resp;
   assign bus.dst_haddr     = sel_aph.haddr;
   assign bus.dst_hwrite    = sel_aph.hwrite;
   assign bus.dst_htrans    = sel_aph.htrans;
   assign bus.dst_hsize     = sel_aph.hsize;
   assign bus.dst_hburst    = sel_aph.hburst;
   assign bus.dst_hprot     = sel_aph.hprot;
   assign bus.dst_hmastlock = sel_aph.hmastlock;
   assign bus.dst_hexcl     = sel_aph.hexcl;
   assign bus.dst_hmaster   = sel_aph.hmaster;
   assign bus.dst_d_pc      = sel_aph.d_pc;
   assign bus.dst_hartid    = sel_aph.hartid;

   assign bus.src_hready_resp = (mast_sel_q & {N_PORTS{bus.dst_hready_resp}}) |
                                (~mast_sel_q & ~buf_valid_q);
   assign bus.src_hresp       = mast_sel_q & {N_PORTS{bus.dst_hresp}};
   assign bus.src_hexokay     = mast_sel_q & {N_PORTS{bus.dst_hexokay}};
   assign bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q  <= '0;
         mast_sel_q   <= '0;
         hold_port_q  <= '0;
         lock_q       <= 1'b0;
         hold_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            mast_sel_q   <= grant;
            lock_q       <= sel_aph.hmastlock;
            hold_valid_q <= 1'b0;
         end else if (bus.dst_hready_resp) begin
            mast_sel_q <= '0;
            lock_q     <= 1'b0;
         end else if (|grant) begin
            hold_valid_q <= 1'b1;
            hold_port_q  <= grant;
         end
         for (int i = 0; i < N_PORTS; i++) begin
            if (accept && grant[i]) buf_valid_q[i] <= 1'b0;
            else if (live[i])       buf_valid_q[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PORTS; i++) begin
         if (live[i] && !(accept && grant[i])) buf_q[i] <= live_aph[i];
      end
   end
endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb/tb_ahbl_arbiter.sv - directed-vector bench for ahbl_arbiter
module tb_ahbl_arbiter;
   localparam int NP = 2;
   localparam int WA = 32;
   localparam int WD = 32;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   ahbl_arbiter_if #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) bus ();

   ahbl_arbiter #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Masters see their own HREADYOUT as HREADY.
   assign bus.src_hready = bus.src_hready_resp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive(input int p, input logic [1:0] tr, input logic [31:0] addr,
                        input logic wr, input logic lk);
      bus.src_htrans[p*2 +: 2]    = tr;
      bus.src_haddr[p*WA +: WA]   = addr;
      bus.src_hwrite[p]           = wr;
      bus.src_hmastlock[p]        = lk;
      bus.src_hsize[p*3 +: 3]     = 3'b010;
      bus.src_hburst[p*3 +: 3]    = 3'b000;
      bus.src_hprot[p*4 +: 4]     = 4'b0011;
      bus.src_hexcl[p]            = 1'b0;
      bus.src_hmaster[p*8 +: 8]   = 8'(p);
      bus.src_d_pc[p*WA +: WA]    = addr;
      bus.src_hartid[p*WD +: WD]  = WD'(p);
   endtask

   task automatic idle(input int p);
      drive(p, 2'b00, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic slave(input logic rdy, input logic err, input logic exok, input logic [31:0] rd);
      bus.dst_hready_resp = rdy;
      bus.dst_hresp       = err;
      bus.dst_hexokay     = exok;
      bus.dst_hrdata      = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      idle(0);
      idle(1);
      bus.src_hwdata = '0;
      slave(1'b1, 1'b0, 1'b1, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk("reset_htrans", bus.dst_htrans, 2'b00);
      chk("reset_hready_resp", bus.src_hready_resp, 2'b11);
      chk("reset_hresp", bus.src_hresp, 2'b00);
      chk("reset_hexokay", bus.src_hexokay, 2'b00);

      // Single zero-wait read from port 0
      drive(0, 2'b10, 32'h2000_0010, 1'b0, 1'b0);
      settle();
      chk("t1_haddr", bus.dst_haddr, 32'h2000_0010);
      chk("t1_htrans", bus.dst_htrans, 2'b10);
      chk("t1_hmaster", bus.dst_hmaster, 8'd0);
      tick();
      idle(0);
      slave(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
      settle();
      chk("t1_hrdata", bus.src_hrdata[31:0], 32'hDEAD_BEEF);
      chk("t1_hready_resp0", bus.src_hready_resp[0], 1'b1);
      chk("t1_hexokay", bus.src_hexokay, 2'b01);
      tick();
      slave(1'b1, 1'b0, 1'b0, 32'h0);

      // Simultaneous requests: port 0 wins, port 1 replays
      drive(0, 2'b10, 32'h100, 1'b0, 1'b0);
      drive(1, 2'b10, 32'h200, 1'b0, 1'b0);
      settle();
      chk("t2_haddr_T", bus.dst_haddr, 32'h100);
      tick();
      idle(0);
      idle(1);
      settle();
      chk("t2_haddr_T1", bus.dst_haddr, 32'h200);
      chk("t2_hmaster_T1", bus.dst_hmaster, 8'd1);
      chk("t2_hready_resp1_T1", bus.src_hready_resp[1], 1'b0);
      tick();
      settle();
      chk("t2_hready_resp1_T2", bus.src_hready_resp[1], 1'b1);
      tick();

      // Port 1 stalled 3 cycles, port 0 arrives in the 2nd stall cycle
      drive(1, 2'b10, 32'h300, 1'b0, 1'b0);
      slave(1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      chk("t3_haddr_s0", bus.dst_haddr, 32'h300);
      tick();
      drive(0, 2'b10, 32'h400, 1'b0, 1'b0);
      settle();
      chk("t3_haddr_s1", bus.dst_haddr, 32'h300);
      tick();
      idle(0);
      settle();
      chk("t3_haddr_s2", bus.dst_haddr, 32'h300);
      tick();
      slave(1'b1, 1'b0, 1'b0, 32'h0);
      settle();
      chk("t3_haddr_s3", bus.dst_haddr, 32'h300);
      tick();
      idle(1);
      settle();
      chk("t3_haddr_after", bus.dst_haddr, 32'h400);
      chk("t3_htrans_after", bus.dst_htrans, 2'b10);
      tick();
      tick();

      // Two-cycle error response on port 0's write
      drive(0, 2'b10, 32'h500, 1'b1, 1'b0);
      settle();
      chk("t4_hwrite", bus.dst_hwrite, 1'b1);
      tick();
      idle(0);
      bus.src_hwdata[31:0] = 32'hCAFE_0001;
      slave(1'b0, 1'b1, 1'b0, 32'h0);
      settle();
      chk("t4_hwdata", bus.dst_hwdata, 32'hCAFE_0001);
      chk("t4_hresp_c1", bus.src_hresp, 2'b01);
      chk("t4_hready_resp_c1", bus.src_hready_resp, 2'b10);
      tick();
      slave(1'b1, 1'b1, 1'b0, 32'h0);
      settle();
      chk("t4_hresp_c2", bus.src_hresp, 2'b01);
      chk("t4_hready_resp_c2", bus.src_hready_resp, 2'b11);
      tick();
      slave(1'b1, 1'b0, 1'b0, 32'h0);
      tick();

      // Locked pair on port 1 while port 0 keeps requesting
      drive(1, 2'b10, 32'h600, 1'b0, 1'b1);
      settle();
      chk("t5_haddr_l0", bus.dst_haddr, 32'h600);
      chk("t5_hmastlock_l0", bus.dst_hmastlock, 1'b1);
      tick();
      drive(0, 2'b10, 32'h700, 1'b0, 1'b0);
      drive(1, 2'b10, 32'h604, 1'b1, 1'b1);
      settle();
      chk("t5_haddr_l1", bus.dst_haddr, 32'h604);
      tick();
      idle(0);
      drive(1, 2'b10, 32'h608, 1'b0, 1'b0);
      bus.src_hwdata = {32'h1234_5678, 32'h0BAD_0BAD};
      settle();
      chk("t5_haddr_l2", bus.dst_haddr, 32'h608);
      chk("t5_hwdata_l2", bus.dst_hwdata, 32'h1234_5678);
      chk("t5_hready_resp0_l2", bus.src_hready_resp[0], 1'b0);
      tick();
      idle(1);
      settle();
      chk("t5_haddr_l3", bus.dst_haddr, 32'h700);
      chk("t5_hmaster_l3", bus.dst_hmaster, 8'd0);
      tick();
      tick();

      // Reset with port 1 buffered and port 0 in data phase
      drive(0, 2'b10, 32'h800, 1'b0, 1'b0);
      drive(1, 2'b10, 32'h900, 1'b0, 1'b0);
      settle();
      chk("t6_haddr_r0", bus.dst_haddr, 32'h800);
      tick();
      idle(0);
      idle(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      slave(1'b1, 1'b0, 1'b1, 32'h0);
      settle();
      chk("t6_htrans_r2", bus.dst_htrans, 2'b00);
      chk("t6_hready_resp_r2", bus.src_hready_resp, 2'b11);
      chk("t6_hexokay_r2", bus.src_hexokay, 2'b00);
      tick();
      settle();
      chk("t6_htrans_r3", bus.dst_htrans, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
